// File: rtl/seg_ctrl_pkg.sv
// Shared types and helpers for the 7-segment shifter controller family.
package seg_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} seg_state_t;

  localparam int DEF_SHIFT_LEN = 64;
  localparam int FRAME_BITS    = 32;

  // Width needed to hold an index 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after `last`, wrapping.
module rr_pick
  import seg_ctrl_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] last,
  output logic                    valid,
  output logic [idx_w(N_REQ)-1:0] idx
);

  localparam int IW = idx_w(N_REQ);

  logic [IW-1:0] w_pos;

  // Walk from the farthest offset to the nearest so the nearest hit is kept.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_pos = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_pos = IW'((int'(last) + k) % N_REQ);
      if (req[w_pos]) begin
        valid = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Shares one serial 7-segment shifter among N_REQ clients and periodically
// re-sends the held value when nobody is asking.
module seg_disp_arbiter
  import seg_ctrl_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SHIFT_LEN = DEF_SHIFT_LEN,
  parameter int REFRESH   = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [FRAME_BITS*N_REQ-1:0] num_in,
  output logic [N_REQ-1:0]            grant,
  output logic [FRAME_BITS-1:0]       num_out,
  output logic                        start,
  output logic                        busy,
  output logic [idx_w(N_REQ)-1:0]     cur_id
);

  localparam int IW  = idx_w(N_REQ);
  localparam int SCW = idx_w(SHIFT_LEN + 1);
  localparam int RCW = idx_w(REFRESH);

  seg_state_t            r_state;
  seg_state_t            w_state_next;
  logic [N_REQ-1:0]      r_grant;
  logic                  r_start;
  logic [FRAME_BITS-1:0] r_num_out;
  logic [IW-1:0]         r_cur_id;
  logic [IW-1:0]         r_last;
  logic [SCW-1:0]        r_shift_cnt;
  logic [RCW-1:0]        r_refresh_cnt;
  logic                  r_first;

  logic                  w_pick_valid;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_refresh_due;
  logic                  w_shift_done;
  logic                  w_load_go;
  logic [FRAME_BITS-1:0] w_slice [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_slice[gi] = num_in[FRAME_BITS*gi +: FRAME_BITS];
    end
  endgenerate

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req   (req),
    .last  (r_last),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_refresh_due = r_first || (r_refresh_cnt == RCW'(REFRESH - 1));
  assign w_shift_done  = (r_shift_cnt == SCW'(SHIFT_LEN - 1));
  assign w_load_go     = (r_state == IDLE) && (w_pick_valid || w_refresh_due);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid || w_refresh_due) w_state_next = LOAD;
      LOAD:    w_state_next = SHIFT;
      SHIFT:   if (w_shift_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant       <= '0;
      r_start       <= 1'b0;
      r_num_out     <= '0;
      r_cur_id      <= '0;
      r_last        <= IW'(N_REQ - 1);
      r_shift_cnt   <= '0;
      r_refresh_cnt <= '0;
      r_first       <= 1'b1;
    end else begin
      r_grant <= '0;
      r_start <= w_load_go;
      if (w_load_go) begin
        r_refresh_cnt <= '0;
        r_first       <= 1'b0;
        r_shift_cnt   <= '0;
        // A refresh keeps the current value and owner; only a pick recaptures.
        if (w_pick_valid) begin
          r_grant   <= N_REQ'(1) << w_pick_idx;
          r_num_out <= w_slice[w_pick_idx];
          r_cur_id  <= w_pick_idx;
          r_last    <= w_pick_idx;
        end
      end else if (r_state == IDLE && r_refresh_cnt != RCW'(REFRESH - 1)) begin
        r_refresh_cnt <= r_refresh_cnt + RCW'(1);
      end
      if (r_state == SHIFT) begin
        r_shift_cnt <= r_shift_cnt + SCW'(1);
      end
    end
  end

  assign grant   = r_grant;
  assign start   = r_start;
  assign num_out = r_num_out;
  assign cur_id  = r_cur_id;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench: a cycle-level timeline model of the arbiter is checked
// against the DUT every cycle, plus literal expectations on key events.
module tb_seg_disp_arbiter;

  localparam int N  = 4;
  localparam int SL = 64;
  localparam int RF = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [32*N-1:0] num_in;
  logic [N-1:0]  grant;
  logic [31:0]   num_out;
  logic          start;
  logic          busy;
  logic [1:0]    cur_id;

  seg_disp_arbiter #(
    .N_REQ     (N),
    .SHIFT_LEN (SL),
    .REFRESH   (RF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .num_in  (num_in),
    .grant   (grant),
    .num_out (num_out),
    .start   (start),
    .busy    (busy),
    .cur_id  (cur_id)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int want [N];

  // Model state: busy cycles left (including the current one), idle run
  // length since the last start, pending-after-reset flag, last winner.
  int          m_rem, m_idle, m_last, m_win;
  bit          m_first, m_found;
  logic [N-1:0] exp_grant;
  logic        exp_start, exp_busy;
  logic [31:0] exp_num;
  logic [1:0]  exp_id;

  int          ev_cyc   [$];
  logic [N-1:0] ev_grant [$];
  logic [31:0] ev_num   [$];
  logic [1:0]  ev_id    [$];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_mis++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, expv, cyc);
    end
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_rem = 0; m_idle = 0; m_first = 1'b1; m_last = N - 1;
      exp_grant = '0; exp_start = 1'b0; exp_num = '0; exp_id = '0;
    end else begin
      exp_grant = '0;
      exp_start = 1'b0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end else begin
        m_found = 1'b0;
        m_win   = 0;
        for (int k = 1; k <= N; k++) begin
          if (!m_found && req[(m_last + k) % N]) begin
            m_found = 1'b1;
            m_win   = (m_last + k) % N;
          end
        end
        if (m_found || m_first || m_idle == RF - 1) begin
          exp_start = 1'b1;
          m_rem     = SL + 1;
          m_idle    = 0;
          m_first   = 1'b0;
          if (m_found) begin
            exp_grant = N'(1) << m_win;
            exp_num   = num_in[32*m_win +: 32];
            exp_id    = 2'(m_win);
            m_last    = m_win;
          end
          ev_cyc.push_back(cyc);
          ev_grant.push_back(exp_grant);
          ev_num.push_back(exp_num);
          ev_id.push_back(exp_id);
        end else if (m_idle < RF - 1) begin
          m_idle = m_idle + 1;
        end
      end
    end
    exp_busy = (m_rem > 0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant",   32'(grant),   32'(exp_grant));
      chk("start",   32'(start),   32'(exp_start));
      chk("busy",    32'(busy),    32'(exp_busy));
      chk("num_out", num_out,      exp_num);
      chk("cur_id",  32'(cur_id),  32'(exp_id));
    end
  end

  task automatic apply_req();
    for (int i = 0; i < N; i++) req[i] = (want[i] > 0);
  endtask

  // A requester drops req for the cycle after its grant, then reasserts if it
  // still has work queued.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (grant[i] === 1'b1) begin
        if (want[i] > 0) want[i]--;
        req[i] = 1'b0;
      end else begin
        req[i] = (want[i] > 0);
      end
    end
  endtask

  task automatic wait_ev(input int n, input int budget, input string what);
    int k;
    k = 0;
    while (ev_cyc.size() <= n && k < budget) begin
      step();
      k++;
    end
    n_vec++;
    if (ev_cyc.size() <= n) begin
      n_mis++;
      $display("FAIL %s: no start within %0d cycles", what, budget);
    end
  endtask

  int t0, n0, cnt;
  logic [N-1:0] rr_seq [5];

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) want[i] = 0;
    num_in = {32'h0BADC0DE, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678};
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);

    // Reset release with no requests: refresh of 0 at cycle 2.
    rst = 1'b0;
    t0 = cyc;
    n0 = ev_cyc.size();
    wait_ev(n0, 10, "first_refresh");
    chk("first_start_cycle", 32'(ev_cyc[n0] - t0 + 1), 32'd2);
    chk("first_start", 32'(start), 32'd1);
    chk("first_num", num_out, 32'h0);
    chk("first_grant", 32'(grant), 32'd0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
    chk("busy_len", 32'(cnt), 32'd65);

    // Single request from requester 0, issued in IDLE.
    want[0] = 1;
    apply_req();
    step();
    chk("b_grant", 32'(grant), 32'b0001);
    chk("b_start", 32'(start), 32'd1);
    chk("b_num", num_out, 32'h12345678);
    chk("b_id", 32'(cur_id), 32'd0);
    n0 = ev_cyc.size() - 1;

    // Requester 2 asks while busy; it must take the very next slot.
    repeat (5) step();
    want[2] = 1;
    wait_ev(n0 + 1, 200, "req2_grant");
    chk("d_grant", 32'(ev_grant[n0 + 1]), 32'b0100);
    chk("d_num", ev_num[n0 + 1], 32'hDEADBEEF);
    chk("d_gap", 32'(ev_cyc[n0 + 1] - ev_cyc[n0]), 32'd66);
    chk("d_dut_id", 32'(cur_id), 32'd2);

    // Idle: three refresh frames re-sending DEADBEEF.
    for (int f = 0; f < 3; f++) begin
      wait_ev(n0 + 2 + f, 400, "refresh");
      chk("r_gap", 32'(ev_cyc[n0 + 2 + f] - ev_cyc[n0 + 1 + f]), 32'd165);
      chk("r_grant", 32'(ev_grant[n0 + 2 + f]), 32'd0);
      chk("r_dut_num", num_out, 32'hDEADBEEF);
      chk("r_dut_id", 32'(cur_id), 32'd2);
    end

    // Fresh reset, all four requesting; requester 0 has two jobs.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
    apply_req();
    t0 = cyc;
    n0 = ev_cyc.size();
    wait_ev(n0, 10, "rr_first");
    chk("c_first_cycle", 32'(ev_cyc[n0] - t0 + 1), 32'd2);
    for (int g = 0; g < 5; g++) begin
      if (g > 0) begin
        wait_ev(n0 + g, 200, "rr_next");
        chk("c_gap", 32'(ev_cyc[n0 + g] - ev_cyc[n0 + g - 1]), 32'd66);
      end
      chk("c_grant", 32'(ev_grant[n0 + g]), 32'(rr_seq[g]));
      chk("c_dut_grant", 32'(grant), 32'(rr_seq[g]));
    end

    // Reset 10 cycles into SHIFT of requester 0's frame.
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("e_busy", 32'(busy), 32'd0);
    chk("e_num", num_out, 32'h0);
    chk("e_start", 32'(start), 32'd0);
    step();
    rst = 1'b0;
    t0 = cyc;
    n0 = ev_cyc.size();
    wait_ev(n0, 10, "post_rst_refresh");
    chk("e_refresh_cycle", 32'(ev_cyc[n0] - t0 + 1), 32'd2);
    chk("e_dut_start", 32'(start), 32'd1);
    chk("e_dut_num", num_out, 32'h0);
    chk("e_dut_grant", 32'(grant), 32'd0);

    // Request present when the post-reset refresh is pending: request wins.
    repeat (3) step();
    rst = 1'b1;
    step();
    want[1] = 1;
    step();
    rst = 1'b0;
    apply_req();
    t0 = cyc;
    n0 = ev_cyc.size();
    wait_ev(n0, 10, "req_beats_refresh");
    chk("f_cycle", 32'(ev_cyc[n0] - t0 + 1), 32'd2);
    chk("f_grant", 32'(ev_grant[n0]), 32'b0010);
    chk("f_num", ev_num[n0], 32'hCAFEF00D);
    chk("f_dut_id", 32'(cur_id), 32'd1);
    repeat (70) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/seg_disp_arbiter.md
# seg_disp_arbiter

Controller and arbiter for the serial 7-segment shifter. It shares the one shifter among N_REQ requesters, each offering a 32-bit hex value. It sequences each load as a one-cycle start pulse followed by the shift window. With no pending requests, it re-sends the last displayed value on a fixed period. It sits between the client logic and the shifter: `num_out` drives the shifter's `num` input, and `start` drives its load strobe.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `SHIFT_LEN`, default 64: shifter bits per frame; cycles the shifter is busy after `start`.
- `REFRESH`, default 50000: idle cycles before an automatic re-send of the held value (must be > 0).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_REQ: level request per requester; held until granted.
- `num_in` in 32*N_REQ: requester i value in bits [32*i+31 : 32*i]; must stay stable while `req[i]`=1.
- `grant` out N_REQ: one-hot, one-cycle pulse; the value of the requester whose bit is set has been captured.
- `num_out` out 32: value under display; drives the shifter.
- `start` out 1: one-cycle load strobe to the shifter.
- `busy` out 1: high from the `start` cycle through the last shift cycle.
- `cur_id` out clog2(N_REQ): index of the requester that owns `num_out`.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - LOAD: `start`=1 for exactly one cycle.
  - SHIFT: counts SHIFT_LEN cycles, then returns to IDLE.
- IDLE, any `req` bit set:
  - Round-robin pick: search from `last+1`, wrapping modulo N_REQ; the first set bit wins.
  - Register `num_out` from the winner's slice, `cur_id`=winner, `last`=winner.
  - Pulse `grant[winner]` and `start` on the next cycle (LOAD).
- IDLE, no request, refresh pending: `start` with `num_out` and `cur_id` unchanged; no `grant`.
- Refresh pending means the refresh counter has reached REFRESH-1, or it is the first IDLE cycle after reset.
- Refresh counter:
  - Clears on every `start`.
  - Increments in IDLE, saturating at REFRESH-1.
  - Holds during LOAD and SHIFT.
- Requests always beat refresh.
- `num_out` is stable from capture until the next capture, never changing in LOAD or SHIFT.
- `req` changes during LOAD or SHIFT have no effect until IDLE.
- A requester deasserts `req` the cycle after it sees `grant`. If `req` is still high in the next IDLE cycle, it is a new request, subject to round-robin.
- Reset values:
  - State IDLE.
  - `num_out`=0, `cur_id`=0, `grant`=0, `start`=0, `busy`=0.
  - `last`=N_REQ-1, so requester 0 has first priority.
  - Refresh counter 0, refresh pending set.
- `rst` mid-LOAD or mid-SHIFT: forced to IDLE next cycle, all outputs to reset values. The pending refresh re-sends 0 and overrides the shifter's partial frame.

## Timing
- Request seen in IDLE at cycle t:
  - `grant` and `start` at t+1.
  - `busy`=1 over t+1 .. t+1+SHIFT_LEN.
  - IDLE again at t+2+SHIFT_LEN.
- Back-to-back requests: next `start` at t+3+SHIFT_LEN. Frame period is SHIFT_LEN+2 cycles (66 at default).
- Refresh: with no requests, `start` recurs every REFRESH + SHIFT_LEN + 1 cycles.
- First `start` after reset release: cycle 2 (one IDLE cycle, then LOAD).
- `grant` and `start` are always coincident when a grant occurs.
- At most one `grant` bit is set in any cycle.

## Structure
- Package `seg_ctrl_pkg`:
  - State enum {IDLE, LOAD, SHIFT}.
  - Default constants SHIFT_LEN=64 and FRAME_BITS=32.
  - Function `idx_w(n)` returning clog2 width.
- Sub-module `rr_pick`: combinational round-robin (inputs `req`, `last`; outputs `valid`, `idx`). Parameterized by N_REQ, reusable by other shared-resource controllers.
- Top holds the FSM, shift counter (clog2(SHIFT_LEN+1) bits), refresh counter, and output registers.

## Test plan
- Reset release, no `req` → `start` at cycle 2 with `num_out`=0x00000000, `busy` high for 65 cycles, no `grant`.
- `req`=0001, `num_in[31:0]`=0x12345678 → `grant`=0001 and `start` one cycle later, `num_out`=0x12345678, `cur_id`=0.
- `req`=1111 held, each requester reasserting after `grant` → grants 0001, 0010, 0100, 1000, 0001, spaced 66 cycles apart.
- Requester 2 asserts with 0xDEADBEEF while `busy`, with a refresh also due → requester 2 granted at the first IDLE; no refresh `start` in between.
- No requests for 3 frames with REFRESH=100 → `start` every 165 cycles, `num_out` and `cur_id` unchanged, `grant`=0.
- `rst` asserted 10 cycles into SHIFT → next cycle `busy`=0, `num_out`=0; refresh `start` 2 cycles after `rst` drops.
